// File: rtl/io_uart_tx_unit.sv
// io_uart_tx_unit: memory-mapped UART transmitter in the IO region.
// Exposes TXDATA (0x0), STATUS (0x4) and CTRL (0x8), buffers outgoing bytes
// in a small circular FIFO and shifts them out as 8N1 frames on o_tx.
module io_uart_tx_unit #(
    parameter logic [1:0] XLEN         = 2'b01,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         CLKS_PER_BIT = 16,
    localparam int        W            = 1 << (XLEN + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_io_en,
    input  logic [W-1:0] i_addr,
    input  logic         i_lw_e,
    input  logic         i_sw_e,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_tx,
    output logic         o_busy,
    output logic         o_bad_offset
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic          full, empty, pop, push, push_ok;

    logic          tx_en, overflow;
    logic [3:0]    off;
    logic          hi_zero, sel_tx, sel_st, sel_ctrl, off_ok;
    logic          wr_en, rd_en, ctrl_wr, stat_rd;
    logic [W-1:0]  rd_val;
    logic          unused_wdata;

    // Only the low byte (TXDATA) and bit 0 (CTRL) of store data matter.
    assign unused_wdata = ^i_wdata[W-1:8];

    // Address decode: only offsets 0x0/0x4/0x8 with a clear upper part are real registers.
    assign off      = i_addr[3:0];
    assign hi_zero  = (i_addr[W-1:4] == '0);
    assign sel_tx   = hi_zero && (off == 4'h0);
    assign sel_st   = hi_zero && (off == 4'h4);
    assign sel_ctrl = hi_zero && (off == 4'h8);
    assign off_ok   = sel_tx | sel_st | sel_ctrl;

    assign o_bad_offset = i_io_en & (i_lw_e | i_sw_e) & ~off_ok;

    // A store wins over a simultaneous load, so that load yields zero.
    assign wr_en   = i_io_en & i_sw_e & off_ok;
    assign rd_en   = i_io_en & i_lw_e & ~i_sw_e & off_ok;
    assign push    = wr_en & sel_tx;
    assign ctrl_wr = wr_en & sel_ctrl;
    assign stat_rd = rd_en & sel_st;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push & (~full | pop);
    assign wr_ptr_n = wr_ptr + (AW+1)'(push_ok);
    assign rd_ptr_n = rd_ptr + (AW+1)'(pop);

    // Load data mux; TXDATA and unmapped bits read as zero.
    always_comb begin
        rd_val = '0;
        if (sel_st) begin
            rd_val[3:0] = {overflow, (state != ST_IDLE), empty, full};
        end else if (sel_ctrl) begin
            rd_val[0] = tx_en;
        end
    end

    // TX FSM next-state: start/data/stop bits each last CLKS_PER_BIT cycles.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    state_n = ST_START;
                    baud_n  = '0;
                    shift_n = mem[rd_ptr[AW-1:0]];
                end
            end
            ST_START: begin
                if (baud == BAUD_LAST) begin
                    state_n   = ST_DATA;
                    baud_n    = '0;
                    bit_cnt_n = 3'd0;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud == BAUD_LAST) begin
                    state_n = ST_IDLE;
                    baud_n  = '0;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Line level is derived from the upcoming state so o_tx lines up with it.
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = shift_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Control registers, counters, pointers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud     <= '0;
            bit_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            tx_en    <= 1'b0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_rdata  <= '0;
        end else begin
            baud    <= baud_n;
            bit_cnt <= bit_cnt_n;
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (stat_rd) begin
                overflow <= 1'b0;
            end
            if (ctrl_wr) begin
                tx_en <= i_wdata[0];
            end
            o_tx    <= tx_n;
            o_busy  <= (state_n != ST_IDLE) || (wr_ptr_n != rd_ptr_n);
            o_rdata <= rd_en ? rd_val : '0;
        end
    end

    // FIFO storage and shift register hold data only and need no reset.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= i_wdata[7:0];
        end
        shift <= shift_n;
    end

endmodule

// File: tb/tb_io_uart_tx_unit.sv
// tb_io_uart_tx_unit: scoreboard bench for io_uart_tx_unit (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_io_uart_tx_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_en = 1'b0;
    logic [31:0] addr = '0;
    logic        lw = 1'b0;
    logic        sw = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;
    logic        bad_offset;

    int checks = 0;
    int failures = 0;
    int rx_frames = 0;

    logic [31:0] exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];
    logic        ld_seen;

    io_uart_tx_unit #(
        .XLEN(2'b01),
        .FIFO_DEPTH(4),
        .CLKS_PER_BIT(4)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_io_en(io_en),
        .i_addr(addr),
        .i_lw_e(lw),
        .i_sw_e(sw),
        .i_wdata(wdata),
        .o_rdata(rdata),
        .o_tx(tx),
        .o_busy(busy),
        .o_bad_offset(bad_offset)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Remember whether a load was presented on the last edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ld_seen <= 1'b0;
        else        ld_seen <= io_en & lw;
    end

    // Load-data monitor: pops an expected value after each load, otherwise requires zero.
    initial begin
        forever begin
            @(negedge clk);
            if (ld_seen) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rdata_unexpected actual=0x%0h required=none", rdata);
                end else begin
                    check("rdata", rdata, exp_rd_q.pop_front());
                end
            end else begin
                check("rdata_idle", rdata, 32'd0);
            end
        end
    end

    // Serial monitor: decodes 8N1 frames at 4 clocks per bit and scores each byte.
    initial begin
        logic       prev_tx;
        logic       act;
        int         cnt;
        logic [7:0] byte_v;
        prev_tx = 1'b1;
        act = 1'b0;
        cnt = 0;
        byte_v = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 1'b0;
            end else if (!act) begin
                if (prev_tx && !tx) begin
                    act = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == 2) check("rx_start_bit", 32'(tx), 32'd0);
                if (cnt >= 6 && cnt <= 34 && ((cnt - 6) % 4) == 0) byte_v[(cnt - 6) / 4] = tx;
                if (cnt == 38) begin
                    check("rx_stop_bit", 32'(tx), 32'd1);
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_unexpected_frame actual=0x%0h required=none", byte_v);
                    end else begin
                        check("rx_byte", 32'(byte_v), 32'(exp_tx_q.pop_front()));
                    end
                    rx_frames++;
                    act = 1'b0;
                end
            end
            prev_tx = tx;
        end
    end

    task automatic bus(input logic en, input logic ld, input logic st,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        logic exp_bad;
        @(negedge clk);
        io_en = en; lw = ld; sw = st; addr = a; wdata = d;
        if (en && ld) exp_rd_q.push_back(exp_rd);
        exp_bad = en && (ld || st) && !(a == 32'h0 || a == 32'h4 || a == 32'h8);
        #1;
        check("bad_offset", 32'(bad_offset), 32'(exp_bad));
        @(posedge clk);
        #1;
        io_en = 1'b0; lw = 1'b0; sw = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, 1'b1, a, d, 32'd0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] exp_rd);
        bus(1'b1, 1'b1, 1'b0, a, 32'd0, exp_rd);
    endtask

    task automatic wait_tx_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("start_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        bit         ok;
        int         frames_before;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        ld(32'h4, 32'h2);
        ld(32'h8, 32'h0);
        ld(32'h0, 32'h0);

        // Bad offsets and disabled IO accesses leave state untouched
        st(32'hC, 32'h1);
        bus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 1'b1, 32'h0, 32'h77, 32'h0);
        ld(32'h8, 32'h0);
        ld(32'h4, 32'h2);
        @(negedge clk);
        check("busy_after_ignored", 32'(busy), 32'd0);

        // Single frame 0xA5 with exact bit timing
        st(32'h8, 32'h1);
        ld(32'h8, 32'h1);
        exp_tx_q.push_back(8'hA5);
        st(32'h0, 32'hA5);
        pat = {1'b1, 8'hA5, 1'b0};
        wait_tx_low(ok);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            check("frame_bit", 32'(tx), 32'(pat[k / 4]));
            if (k == 39) check("busy_last_cycle", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("busy_end", 32'(busy), 32'd0);
        check("tx_idle_after", 32'(tx), 32'd1);
        check("frames_single", rx_frames, 32'd1);

        // Overflow with transmitter disabled
        st(32'h8, 32'h0);
        st(32'h0, 32'h11);
        st(32'h0, 32'h22);
        st(32'h0, 32'h33);
        st(32'h0, 32'h44);
        st(32'h0, 32'h55);
        ld(32'h4, 32'h9);
        ld(32'h4, 32'h1);
        @(negedge clk);
        check("busy_queued_disabled", 32'(busy), 32'd1);
        frames_before = rx_frames;
        exp_tx_q.push_back(8'h11);
        exp_tx_q.push_back(8'h22);
        exp_tx_q.push_back(8'h33);
        exp_tx_q.push_back(8'h44);
        st(32'h8, 32'h1);
        wait_idle(400);
        check("frames_overflow", rx_frames - frames_before, 32'd4);
        ld(32'h4, 32'h2);

        // Push and pop on the same edge while full
        st(32'h8, 32'h0);
        st(32'h0, 32'h11);
        st(32'h0, 32'h22);
        st(32'h0, 32'h33);
        st(32'h0, 32'h44);
        ld(32'h4, 32'h1);
        frames_before = rx_frames;
        exp_tx_q.push_back(8'h11);
        exp_tx_q.push_back(8'h22);
        exp_tx_q.push_back(8'h33);
        exp_tx_q.push_back(8'h44);
        exp_tx_q.push_back(8'h55);
        st(32'h8, 32'h1);
        st(32'h0, 32'h55);
        ld(32'h4, 32'h5);
        wait_idle(500);
        check("frames_push_pop", rx_frames - frames_before, 32'd5);
        ld(32'h4, 32'h2);

        // Simultaneous load and store: store wins, load data zero
        bus(1'b1, 1'b1, 1'b1, 32'h8, 32'h0, 32'h0);
        ld(32'h8, 32'h0);

        // Reset in the middle of data bit 3 of 0xC3
        st(32'h8, 32'h1);
        st(32'h0, 32'hC3);
        wait_tx_low(ok);
        repeat (18) @(negedge clk);
        check("tx_bit3_before_reset", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_tx", 32'(tx), 32'd1);
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ld(32'h4, 32'h2);
        ld(32'h8, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_tx_idle", 32'(tx), 32'd1);
        end
        check("post_reset_busy", 32'(busy), 32'd0);

        repeat (2) @(negedge clk);
        check("exp_tx_drained", 32'(exp_tx_q.size()), 32'd0);
        check("exp_rd_drained", 32'(exp_rd_q.size()), 32'd0);
        check("frames_total", rx_frames, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
